// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//   Shares a WIDTH-bit 2:1 mux between two valid/ready requesters. The mux
//   select is granted round-robin, and the chosen word is registered into a
//   one-entry output stage that has its own valid/ready handshake.
//
// Ports
//   clk      system clock; all state updates on the rising edge
//   rst      synchronous, active-high reset
//   I0/V0/R0 requester 0 data / valid / ready
//   I1/V1/R1 requester 1 data / valid / ready
//   Y/YV/YR  registered output data / valid / downstream ready
//   S        registered select of the word held in Y (0 = I0, 1 = I1)
module mux_rr_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] I0,
  input  logic             V0,
  output logic             R0,
  input  logic [WIDTH-1:0] I1,
  input  logic             V1,
  output logic             R1,
  output logic [WIDTH-1:0] Y,
  output logic             YV,
  input  logic             YR,
  output logic             S
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             s_q, s_d;
  logic             p_q, p_d;   // priority pointer: 0 favours requester 0

  logic load;
  logic g0, g1;

  always_comb begin
    // The stage can accept a new word when empty or when its word drains now.
    load = (state_q == ST_EMPTY) | YR;

    // A tie goes to the requester the pointer favours; otherwise to whoever is valid.
    g0 = load & V0 & (~V1 | ~p_q);
    g1 = load & V1 & (~V0 |  p_q);

    state_d = state_q;
    y_d     = y_q;
    s_d     = s_q;
    p_d     = p_q;

    if (load) begin
      if (g0 | g1) begin
        state_d = ST_FULL;
        y_d     = g1 ? I1 : I0;
        s_d     = g1;
        p_d     = ~g1;
      end else begin
        state_d = ST_EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      y_q     <= '0;
      s_q     <= 1'b0;
      p_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      s_q     <= s_d;
      p_q     <= p_d;
    end
  end

  // Ready is masked during reset so no handshake completes on a reset cycle.
  assign R0 = g0 & ~rst;
  assign R1 = g1 & ~rst;
  assign Y  = y_q;
  assign YV = (state_q == ST_FULL);
  assign S  = s_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] I0, I1;
  logic             V0, V1;
  logic             R0, R1;
  logic [WIDTH-1:0] Y;
  logic             YV;
  logic             YR;
  logic             S;

  int errors = 0;
  int checks = 0;

  mux_rr_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .I0(I0), .V0(V0), .R0(R0),
    .I1(I1), .V1(V1), .R1(R1),
    .Y(Y), .YV(YV), .YR(YR), .S(S)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; V0 = 1'b1; V1 = 1'b1; I0 = 16'h00AF; I1 = 16'h00FA; YR = 1'b1;
    #1;
    checks++; if (R0 !== 1'b0) begin errors++; $display("FAIL reset_r0_during: got %b expected 0", R0); end
    checks++; if (R1 !== 1'b0) begin errors++; $display("FAIL reset_r1_during: got %b expected 0", R1); end
    tick();
    tick();
    checks++; if (Y !== 16'h0000) begin errors++; $display("FAIL reset_y: got %h expected 0000", Y); end
    checks++; if (YV !== 1'b0) begin errors++; $display("FAIL reset_yv: got %b expected 0", YV); end
    checks++; if (S !== 1'b0) begin errors++; $display("FAIL reset_s: got %b expected 0", S); end
    checks++; if (R0 !== 1'b0 || R1 !== 1'b0) begin errors++; $display("FAIL reset_ready: got R0=%b R1=%b expected 0 0", R0, R1); end
    rst = 1'b0;
    #1;
    checks++; if (R0 !== 1'b1 || R1 !== 1'b0) begin errors++; $display("FAIL reset_first_grant: got R0=%b R1=%b expected 1 0", R0, R1); end
    tick();
    checks++; if (Y !== 16'h00AF || S !== 1'b0 || YV !== 1'b1) begin
      errors++; $display("FAIL reset_first_word: got Y=%h S=%b YV=%b expected 00af 0 1", Y, S, YV);
    end
    V0 = 1'b0; V1 = 1'b0;
    tick();
    checks++; if (YV !== 1'b0) begin errors++; $display("FAIL reset_drain: got YV=%b expected 0", YV); end
  endtask

  task automatic test_single();
    I0 = 16'h00AF; V0 = 1'b1; V1 = 1'b0; YR = 1'b1;
    #1;
    checks++; if (R0 !== 1'b1 || R1 !== 1'b0) begin errors++; $display("FAIL single_ready: got R0=%b R1=%b expected 1 0", R0, R1); end
    tick();
    checks++; if (Y !== 16'h00AF || S !== 1'b0 || YV !== 1'b1) begin
      errors++; $display("FAIL single_word: got Y=%h S=%b YV=%b expected 00af 0 1", Y, S, YV);
    end
    V0 = 1'b0;
    #1;
    checks++; if (R0 !== 1'b0) begin errors++; $display("FAIL single_r0_drop: got %b expected 0", R0); end
    tick();
    checks++; if (YV !== 1'b0 || Y !== 16'h00AF || S !== 1'b0) begin
      errors++; $display("FAIL single_empty_hold: got YV=%b Y=%h S=%b expected 0 00af 0", YV, Y, S);
    end
  endtask

  task automatic test_round_robin();
    logic [WIDTH-1:0] exp_y [4];
    logic             exp_s [4];
    exp_y = '{16'h00AF, 16'h00FA, 16'h00AF, 16'h00FA};
    exp_s = '{1'b0, 1'b1, 1'b0, 1'b1};
    // Reset so the pointer starts at requester 0.
    rst = 1'b1; V0 = 1'b0; V1 = 1'b0;
    tick();
    rst = 1'b0;
    I0 = 16'h00AF; I1 = 16'h00FA; V0 = 1'b1; V1 = 1'b1; YR = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (R0 !== ~exp_s[i] || R1 !== exp_s[i]) begin
        errors++; $display("FAIL rr_ready[%0d]: got R0=%b R1=%b expected %b %b", i, R0, R1, ~exp_s[i], exp_s[i]);
      end
      tick();
      checks++; if (Y !== exp_y[i] || S !== exp_s[i] || YV !== 1'b1) begin
        errors++; $display("FAIL rr_word[%0d]: got Y=%h S=%b YV=%b expected %h %b 1", i, Y, S, YV, exp_y[i], exp_s[i]);
      end
    end
  endtask

  task automatic test_back_pressure();
    // Stage holds 00FA from requester 1; only requester 0 asks now.
    V1 = 1'b0; V0 = 1'b1; I0 = 16'h00AF; YR = 1'b0;
    #1;
    checks++; if (R0 !== 1'b0) begin errors++; $display("FAIL bp_r0_stall: got %b expected 0", R0); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (Y !== 16'h00FA || S !== 1'b1 || YV !== 1'b1 || R0 !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d]: got Y=%h S=%b YV=%b R0=%b expected 00fa 1 1 0", i, Y, S, YV, R0);
      end
    end
    YR = 1'b1;
    #1;
    checks++; if (R0 !== 1'b1) begin errors++; $display("FAIL bp_release_r0: got %b expected 1", R0); end
    tick();
    checks++; if (Y !== 16'h00AF || S !== 1'b0 || YV !== 1'b1) begin
      errors++; $display("FAIL bp_next_word: got Y=%h S=%b YV=%b expected 00af 0 1", Y, S, YV);
    end
  endtask

  task automatic test_back_to_back();
    // Stage is full with 00AF; drain and refill in the same cycle.
    V0 = 1'b0; V1 = 1'b1; I1 = 16'h1234; YR = 1'b1;
    #1;
    checks++; if (R1 !== 1'b1 || R0 !== 1'b0) begin errors++; $display("FAIL b2b_ready: got R0=%b R1=%b expected 0 1", R0, R1); end
    tick();
    checks++; if (YV !== 1'b1 || Y !== 16'h1234 || S !== 1'b1) begin
      errors++; $display("FAIL b2b_word: got YV=%b Y=%h S=%b expected 1 1234 1", YV, Y, S);
    end
    // Lone requester keeps full rate despite the pointer moving.
    V1 = 1'b0; V0 = 1'b1; I0 = 16'h0001;
    tick();
    checks++; if (Y !== 16'h0001 || S !== 1'b0 || YV !== 1'b1) begin
      errors++; $display("FAIL b2b_lone0: got Y=%h S=%b YV=%b expected 0001 0 1", Y, S, YV);
    end
    I0 = 16'h0002;
    #1;
    checks++; if (R0 !== 1'b1) begin errors++; $display("FAIL b2b_lone_ready: got %b expected 1", R0); end
    tick();
    checks++; if (Y !== 16'h0002 || YV !== 1'b1) begin
      errors++; $display("FAIL b2b_lone1: got Y=%h YV=%b expected 0002 1", Y, YV);
    end
    V0 = 1'b0;
    tick();
    checks++; if (YV !== 1'b0 || Y !== 16'h0002) begin
      errors++; $display("FAIL b2b_drain: got YV=%b Y=%h expected 0 0002", YV, Y);
    end
  endtask

  task automatic test_reset_mid();
    V0 = 1'b1; V1 = 1'b0; I0 = 16'h00AF; I1 = 16'h00FA; YR = 1'b1;
    tick();
    checks++; if (Y !== 16'h00AF || YV !== 1'b1) begin
      errors++; $display("FAIL mid_setup: got Y=%h YV=%b expected 00af 1", Y, YV);
    end
    // Pointer now favours requester 1; reset must restore requester 0.
    rst = 1'b1; V1 = 1'b1; YR = 1'b1;
    #1;
    checks++; if (R0 !== 1'b0 || R1 !== 1'b0) begin errors++; $display("FAIL mid_ready_rst: got R0=%b R1=%b expected 0 0", R0, R1); end
    tick();
    checks++; if (YV !== 1'b0 || Y !== 16'h0000 || S !== 1'b0) begin
      errors++; $display("FAIL mid_cleared: got YV=%b Y=%h S=%b expected 0 0000 0", YV, Y, S);
    end
    rst = 1'b0;
    #1;
    checks++; if (R0 !== 1'b1 || R1 !== 1'b0) begin errors++; $display("FAIL mid_pointer: got R0=%b R1=%b expected 1 0", R0, R1); end
    tick();
    checks++; if (Y !== 16'h00AF || S !== 1'b0 || YV !== 1'b1) begin
      errors++; $display("FAIL mid_regrant: got Y=%h S=%b YV=%b expected 00af 0 1", Y, S, YV);
    end
    V0 = 1'b0; V1 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; V0 = 1'b0; V1 = 1'b0; I0 = '0; I1 = '0; YR = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected finish within 100000 time units");
    $fatal(1);
  end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Shares the team's 16-bit 2:1 mux datapath (inputs I0/I1, select S, output Y) between two requesters.
- Each requester offers a word on a valid/ready channel. The block grants the mux select round-robin and registers the selected word into a one-entry output stage with its own valid/ready handshake.
- Sits between two producer blocks and a single downstream consumer.

Parameters:
- WIDTH, 16, data width of I0, I1 and Y.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- I0  input  WIDTH  requester 0 data.
- V0  input  1  requester 0 valid.
- R0  output  1  requester 0 ready (word accepted when V0 & R0).
- I1  input  WIDTH  requester 1 data.
- V1  input  1  requester 1 valid.
- R1  output  1  requester 1 ready (word accepted when V1 & R1).
- Y  output  WIDTH  registered output data.
- YV  output  1  output valid.
- YR  input  1  downstream ready (word consumed when YV & YR).
- S  output  1  registered select of the word currently in Y (0 = I0, 1 = I1).

Behaviour:
- Clock and reset: one clock domain, clk. rst is synchronous and active-high.
- Reset (rst=1 at posedge) forces:
  - Y=0, YV=0, S=0.
  - Priority pointer P=0 (P=0 favours requester 0).
- Reset mid-operation: a word held in Y is discarded and no handshake completes that cycle. R0 and R1 are 0 while rst=1.
- Output stage is a 2-state FSM:
  - EMPTY: YV=0.
  - FULL: YV=1.
- Load enable: L = ~YV | YR. The stage can take a new word in the same cycle the old one drains, which gives full throughput.
- Grant, combinational, evaluated only when L=1:
  - V0 & ~V1 -> g0.
  - V1 & ~V0 -> g1.
  - V0 & V1 -> g0 if P=0, else g1.
  - neither valid -> no grant.
- Ready outputs:
  - R0 = L & g0 & ~rst.
  - R1 = L & g1 & ~rst.
  - R0 and R1 are never both 1.
  - Ready may depend on the requesters' valid. Requesters must not make valid depend on ready.
- On a grant at posedge:
  - Y <= selected data; S <= granted index; YV <= 1.
  - P <= ~granted index, so the loser of a tie wins next. P updates on every grant, including uncontested ones.
- L=1 with no grant: YV <= 0; Y and S hold their last values.
- L=0 (YV=1, YR=0): Y, S, YV and P all hold. R0 and R1 are 0 (back-pressure).
- FSM transitions:
  - EMPTY -> FULL on any grant.
  - FULL -> FULL on a grant with YR=1, or when YR=0.
  - FULL -> EMPTY on YR=1 with no grant.
- Latency: one cycle from an accepted request (Vx & Rx) to YV=1 with the word on Y.
- Throughput: one word per cycle. With both requesters continuously valid and YR=1, grants strictly alternate.
- Fairness: with both valid, neither requester waits more than one grant.
- Data requirement: requesters hold data and valid stable until accepted. The block does not check this.

Test Plan:
- Reset: rst=1 for 2 cycles with V0=V1=1 -> Y=0000, YV=0, S=0, R0=R1=0. After release, first grant goes to I0.
- Single requester: I0=00AF, V0=1, V1=0, YR=1 -> R0=1. Next cycle Y=00AF, S=0, YV=1. Dropping V0 -> YV=0 the following cycle.
- Contention with round-robin: I0=00AF, I1=00FA, V0=V1=1, YR=1 for 4 cycles -> Y sequence 00AF, 00FA, 00AF, 00FA with S=0,1,0,1.
- Back-pressure: FULL with Y=00FA, YR=0 for 3 cycles while V0=1 -> Y, S, YV stable and R0=0. YR=1 -> R0=1 and the next Y=00AF.
- Drain and refill in the same cycle: YV=1, YR=1, V1=1, I1=1234 -> no bubble. YV stays 1 and Y=1234 the next cycle.
- Reset mid-transfer: YV=1, Y=00AF, assert rst for 1 cycle -> YV=0, Y=0000, P=0. No spurious handshake on R0 or R1.
